// File: rtl/pc_halt_monitor.sv
// Watches the committed-PC stream and declares a run finished when the PC holds
// at one address for HOLD_CYCLES valid samples, or when the cycle budget runs out.
module pc_halt_monitor #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned MAX_CYCLES  = 2400,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pc_valid,
  input  logic [31:0]      pc,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [31:0]      halt_pc,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [7:0]       HoldMax = 8'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(MAX_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [7:0]       stable_q, stable_d;
  logic             seen_q, seen_d;
  logic             done_q, done_d;
  logic             halted_q, halted_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      halt_pc_q, halt_pc_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_pc_d = last_pc_q;
    stable_d  = stable_q;
    seen_d    = seen_q;
    done_d    = done_q;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    halt_pc_d = halt_pc_q;

    unique case (state_q)
      StRun: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (pc_valid) begin
          if (!seen_q || (pc != last_pc_q)) begin
            last_pc_d = pc;
            stable_d  = 8'd1;
            seen_d    = 1'b1;
          end else if (stable_q != HoldMax) begin
            stable_d = stable_q + 8'd1;
          end
        end
        // Halt is checked first so it wins a tie with the budget expiring.
        if (stable_d == HoldMax) begin
          state_d   = StDone;
          done_d    = 1'b1;
          halted_d  = 1'b1;
          halt_pc_d = last_pc_d;
        end else if (cnt_d == CntMax) begin
          state_d   = StDone;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          halt_pc_d = seen_d ? last_pc_d : 32'h0;
        end
      end
      default: ;
    endcase

    // A start pulse re-arms from any state; its own PC sample is dropped.
    if (start) begin
      state_d   = StRun;
      cnt_d     = '0;
      stable_d  = 8'd0;
      seen_d    = 1'b0;
      done_d    = 1'b0;
      halted_d  = 1'b0;
      timeout_d = 1'b0;
      halt_pc_d = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_pc_q <= 32'h0;
      stable_q  <= 8'd0;
      seen_q    <= 1'b0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      halt_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_pc_q <= last_pc_d;
      stable_q  <= stable_d;
      seen_q    <= seen_d;
      done_q    <= done_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      halt_pc_q <= halt_pc_d;
    end
  end

  assign running     = (state_q == StRun);
  assign done        = done_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign halt_pc     = halt_pc_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_halt_monitor.sv
// Directed plus randomized bench for pc_halt_monitor; a history-of-samples model
// supplies every expected output.
module tb_pc_halt_monitor;

  localparam int H = 4;
  localparam int M = 2400;
  localparam int W = 16;
  localparam logic [31:0] Base = 32'h0040_0020;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          pc_valid;
  logic [31:0]   pc;
  logic          running;
  logic          done;
  logic          halted;
  logic          timeout;
  logic [31:0]   halt_pc;
  logic [W-1:0]  cycle_count;

  pc_halt_monitor #(
    .HOLD_CYCLES(H),
    .MAX_CYCLES (M),
    .CNT_W      (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pc_valid   (pc_valid),
    .pc         (pc),
    .running    (running),
    .done       (done),
    .halted     (halted),
    .timeout    (timeout),
    .halt_pc    (halt_pc),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the list of valid PCs seen since start decides everything.
  logic        m_running, m_done, m_halted, m_timeout;
  logic [31:0] m_halt_pc;
  int          m_cnt;
  logic [31:0] samples[$];

  task automatic model_reset();
    m_running = 0; m_done = 0; m_halted = 0; m_timeout = 0;
    m_halt_pc = 0; m_cnt = 0;
    samples.delete();
  endtask

  task automatic model_step(input logic v, input logic [31:0] p, input logic st);
    bit held;
    if (st) begin
      model_reset();
      m_running = 1;
      return;
    end
    if (!m_running) return;
    m_cnt++;
    if (v) samples.push_back(p);
    held = (samples.size() >= H);
    if (held)
      for (int i = 1; i < H; i++)
        if (samples[samples.size() - 1 - i] != samples[samples.size() - 1]) held = 0;
    if (held) begin
      m_running = 0; m_done = 1; m_halted = 1;
      m_halt_pc = samples[samples.size() - 1];
    end else if (m_cnt == M) begin
      m_running = 0; m_done = 1; m_timeout = 1;
      m_halt_pc = (samples.size() > 0) ? samples[samples.size() - 1] : 32'h0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".running"}, 32'(running), 32'(m_running));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halted));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_timeout));
    chk({tag, ".halt_pc"}, halt_pc, m_halt_pc);
    chk({tag, ".cycle_count"}, 32'(cycle_count), 32'(m_cnt));
  endtask

  task automatic step(input logic v, input logic [31:0] p, input logic st, input string tag);
    start = st; pc_valid = v; pc = p;
    @(posedge clk);
    #1;
    start = 0; pc_valid = 0;
    model_step(v, p, st);
    check_all(tag);
  endtask

  task automatic do_start(input string tag);
    step(1'($urandom_range(0, 1)), $urandom, 1'b1, tag);
  endtask

  initial begin
    logic [31:0] p;
    logic        v;

    rst_n = 0; start = 0; pc_valid = 0; pc = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk) rst_n = 1;

    // Directed halt
    do_start("halt.start");
    step(1, Base, 0, "halt");
    step(1, Base + 4, 0, "halt");
    step(1, Base + 8, 0, "halt");
    for (int i = 0; i < 4; i++) step(1, Base + 12, 0, "halt");
    chk("halt.done_const", 32'(done), 32'd1);
    chk("halt.pc_const", halt_pc, 32'h0040_002C);
    chk("halt.cnt_const", 32'(cycle_count), 32'd7);
    step(1, 32'h1234_5678, 0, "halt.hold");

    // Gap tolerance
    do_start("gap.start");
    step(1, Base, 0, "gap");
    step(1, Base + 4, 0, "gap");
    step(1, Base + 8, 0, "gap");
    step(1, Base + 12, 0, "gap");
    step(1, Base + 12, 0, "gap");
    step(0, Base + 12, 0, "gap");
    step(0, 32'hDEAD_BEEF, 0, "gap");
    step(1, Base + 12, 0, "gap");
    step(1, Base + 12, 0, "gap");
    chk("gap.halted_const", 32'(halted), 32'd1);
    chk("gap.cnt_const", 32'(cycle_count), 32'd9);

    // Interrupted hold needs four fresh equal samples
    do_start("brk.start");
    step(1, Base, 0, "brk");
    step(1, Base + 4, 0, "brk");
    step(1, Base + 8, 0, "brk");
    step(1, Base + 12, 0, "brk");
    step(1, Base + 12, 0, "brk");
    step(1, Base + 16, 0, "brk");
    step(1, Base + 12, 0, "brk");
    step(1, Base + 12, 0, "brk");
    step(1, Base + 12, 0, "brk");
    chk("brk.not_yet", 32'(done), 32'd0);
    step(1, Base + 12, 0, "brk");
    chk("brk.halted_const", 32'(halted), 32'd1);

    // Timeout
    do_start("to.start");
    for (int k = 1; k <= M; k++) step(1, Base + 32'(4 * (k - 1)), 0, "to");
    chk("to.timeout_const", 32'(timeout), 32'd1);
    chk("to.halted_const", 32'(halted), 32'd0);
    chk("to.cnt_const", 32'(cycle_count), 32'd2400);
    chk("to.pc_const", halt_pc, Base + 32'(4 * 2399));

    // Tie: fourth equal sample on the last budget cycle
    do_start("tie.start");
    for (int k = 1; k <= M; k++) begin
      p = (k <= M - 3) ? Base + 32'(4 * (k - 1)) : Base + 32'(4 * (M - 4));
      step(1, p, 0, "tie");
    end
    chk("tie.halted_const", 32'(halted), 32'd1);
    chk("tie.timeout_const", 32'(timeout), 32'd0);

    // Timeout with no valid PC ever seen
    do_start("tonv.start");
    for (int k = 1; k <= M; k++) step(0, $urandom, 0, "tonv");
    chk("tonv.pc_const", halt_pc, 32'h0);

    // Asynchronous reset mid-run
    do_start("rst.start");
    for (int k = 1; k <= 50; k++) step(1, Base + 32'(4 * (k - 1)), 0, "rst");
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("rst.async");
    @(negedge clk) rst_n = 1;
    step(1, Base, 0, "rst.idle");

    // Restart after a halt
    do_start("rs1.start");
    for (int i = 0; i < 4; i++) step(1, Base, 0, "rs1");
    do_start("rs2.start");
    chk("rs2.done_const", 32'(done), 32'd0);
    step(1, 32'h0040_0100, 0, "rs2");
    chk("rs2.cnt_const", 32'(cycle_count), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 32'h0040_0100, 0, "rs2");
    chk("rs2.pc_const", halt_pc, 32'h0040_0100);

    // Randomized runs, occasional restarts mid-run
    for (int r = 0; r < 30; r++) begin
      do_start("rnd.start");
      for (int c = 0; c < 40; c++) begin
        v = ($urandom_range(0, 3) != 0);
        p = Base + 32'(4 * $urandom_range(0, 1));
        step(v, p, 1'($urandom_range(0, 40) == 0), "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
